// File: rtl/pio_in_capture_if.sv
// Avalon-MM s1 register port of the input PIO.
// The master drives the bus and the slave returns readdata.
interface pio_in_capture_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_capture.sv
// Input PIO: sync, edge detect, sticky W1C edgecapture, maskable level irq.
// Define PIO_IN_DEBOUNCE_EN to add a per-bit debounce filter.
module pio_in_capture #(
  parameter int               WIDTH           = 8,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_in_capture_if.slave  s1,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_ec;
  logic [WIDTH-1:0] r_mask;
  logic             r_primed;

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1
                    : $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_filt;

  // any disagreement that does not persist restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (int'(r_cnt[i]) + 1 >= DEBOUNCE_CYCLES) begin
            r_filt[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;

  assign w_filt = r_sync2;
`endif

  always_comb begin
    w_raw = '0;
    case (EDGE_TYPE)
      0:       w_raw = w_filt & ~r_prev;
      1:       w_raw = ~w_filt & r_prev;
      default: w_raw = w_filt ^ r_prev;
    endcase
  end

  // first clock after reset only loads prev
  assign w_edge = r_primed ? w_raw : '0;

  assign w_wr  = s1.chipselect & ~s1.write_n;
  assign w_clr = (w_wr && s1.address == 2'd3)
               ? s1.writedata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_ec     <= '0;
      r_mask   <= IRQ_MASK_RESET;
    end else begin
      r_prev   <= w_filt;
      r_primed <= 1'b1;
      r_ec     <= (r_ec & ~w_clr) | w_edge;
      if (w_wr && s1.address == 2'd2) begin
        r_mask <= s1.writedata;
      end
    end
  end

  always_comb begin
    s1.readdata = '0;
    case (s1.address)
      2'd0:    s1.readdata = w_filt;
      2'd2:    s1.readdata = r_mask;
      2'd3:    s1.readdata = r_ec;
      default: s1.readdata = '0;
    endcase
  end

  assign irq = |(r_ec & r_mask);

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: rising-edge and any-edge instances
// on a shared bus; debounce scenario when PIO_IN_DEBOUNCE_EN is defined.
module tb_pio_in_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       irq_a;
  logic       irq_b;
  logic [1:0] address;
  logic       cs;
  logic       wr_n;
  logic [7:0] wdata;
  logic [7:0] d;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pio_in_capture_if #(.WIDTH(8)) bus_a ();
  pio_in_capture_if #(.WIDTH(8)) bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = cs;
  assign bus_a.write_n    = wr_n;
  assign bus_a.writedata  = wdata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = cs;
  assign bus_b.write_n    = wr_n;
  assign bus_b.writedata  = wdata;

  pio_in_capture #(
    .WIDTH(8),
    .EDGE_TYPE(0)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .s1(bus_a.slave),
    .in_port(in_a),
    .irq(irq_a)
  );

  pio_in_capture #(
    .WIDTH(8),
    .EDGE_TYPE(2)
  ) u_any (
    .clk(clk),
    .reset_n(reset_n),
    .s1(bus_b.slave),
    .in_port(in_b),
    .irq(irq_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    address = a;
    wdata   = v;
    cs      = 1'b1;
    wr_n    = 1'b0;
    @(posedge clk);
    #1;
    cs   = 1'b0;
    wr_n = 1'b1;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = bus_a.readdata;
  endtask

  task automatic rd_b(input logic [1:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = bus_b.readdata;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_a = 8'hFF;
    in_b = 8'h08;
    cs = 1'b0;
    wr_n = 1'b1;
    address = 2'd0;
    wdata = 8'h00;
    tick(3);
    rd_a(2'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL rst_data: got %h expected 00", d);
    end
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL rst_ec: got %h expected 00", d);
    end
    rd_a(2'd2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL rst_mask: got %h expected 00", d);
    end
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: got %b expected 0", irq_a);
    end
    reset_n = 1'b1;
    tick(1);
    rd_a(2'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL data_clk1: got %h expected 00", d);
    end
    tick(1);
    rd_a(2'd0, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL data_clk2: got %h expected ff", d);
    end
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL ec_clk2: got %h/%b expected 00/0", d, irq_a);
    end
    in_a = 8'h00;
    tick(6);
    wr(2'd3, 8'hFF);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL ec_cleared: got %h expected 00", d);
    end
  endtask

  task automatic test_rise_irq;
    wr(2'd2, 8'h01);
    in_a = 8'h01;
    tick(2);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL rise_early: got %h/%b expected 00/0", d, irq_a);
    end
    tick(1);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h01 || irq_a !== 1'b1) begin
      errors++;
      $display("FAIL rise_clk3: got %h/%b expected 01/1", d, irq_a);
    end
    wr(2'd3, 8'h01);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq: got %h/%b expected 00/0", d, irq_a);
    end
  endtask

  task automatic test_set_wins;
    in_a = 8'h05;
    tick(2);
    wr(2'd3, 8'h04);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("FAIL set_wins: got %h expected 04", d);
    end
    wr(2'd3, 8'h00);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("FAIL w1c_zero: got %h expected 04", d);
    end
    wr(2'd3, 8'h04);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL w1c_bit2: got %h expected 00", d);
    end
  endtask

  task automatic test_mask;
    wr(2'd2, 8'h00);
    in_a = 8'h25;
    tick(3);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h20 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL masked: got %h/%b expected 20/0", d, irq_a);
    end
    wr(2'd2, 8'h20);
    checks++;
    if (irq_a !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq: got %b expected 1", irq_a);
    end
    wr(2'd1, 8'hFF);
    rd_a(2'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL reserved: got %h expected 00", d);
    end
    rd_a(2'd2, d);
    checks++;
    if (d !== 8'h20) begin
      errors++;
      $display("FAIL mask_rd: got %h expected 20", d);
    end
    wr(2'd3, 8'h20);
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL mask_clr: got %b expected 0", irq_a);
    end
  endtask

  task automatic test_any_edge;
    in_b = 8'h00;
    tick(3);
    rd_b(2'd3, d);
    checks++;
    if (d !== 8'h08) begin
      errors++;
      $display("FAIL any_fall: got %h expected 08", d);
    end
    tick(1);
    wr(2'd3, 8'h08);
    rd_b(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL any_clr: got %h expected 00", d);
    end
    in_b = 8'h08;
    tick(2);
    rd_b(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL any_early: got %h expected 00", d);
    end
    tick(1);
    rd_b(2'd3, d);
    checks++;
    if (d !== 8'h08) begin
      errors++;
      $display("FAIL any_rise: got %h expected 08", d);
    end
    wr(2'd3, 8'h08);
  endtask

  task automatic test_back_to_back;
    in_a = 8'h65;
    tick(2);
    in_a = 8'h25;
    tick(2);
    in_a = 8'h65;
    tick(4);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h40) begin
      errors++;
      $display("FAIL collapse: got %h expected 40", d);
    end
    wr(2'd3, 8'hFF);
    in_a = 8'h25;
    tick(4);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL no_fall: got %h expected 00", d);
    end
  endtask

`ifdef PIO_IN_DEBOUNCE_EN
  task automatic test_debounce;
    reset_n = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    cs = 1'b0;
    wr_n = 1'b1;
    address = 2'd0;
    wdata = 8'h00;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      in_a = 8'h01;
      tick(4);
      in_a = 8'h00;
      tick(4);
    end
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL db_bounce: got %h expected 00", d);
    end
    in_a = 8'h01;
    tick(18);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL db_early: got %h expected 00", d);
    end
    tick(1);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL db_capture: got %h expected 01", d);
    end
    in_a = 8'h00;
    tick(10);
    reset_n = 1'b0;
    in_a = 8'h01;
    tick(1);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL db_rst_ec: got %h expected 00", d);
    end
    rd_a(2'd0, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL db_rst_data: got %h expected 00", d);
    end
    reset_n = 1'b1;
    tick(18);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL db_post_early: got %h expected 00", d);
    end
    tick(1);
    rd_a(2'd3, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL db_post_cap: got %h expected 01", d);
    end
  endtask
`endif

  initial begin
`ifdef PIO_IN_DEBOUNCE_EN
    test_debounce();
`else
    test_reset();
    test_rise_irq();
    test_set_wins();
    test_mask();
    test_any_edge();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
